int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt source controller between the peripheral request lines and the core's `int_flag_i` input. It latches rising edges on up to 8 external request lines as pending bits and masks them with a software enable register. It presents the highest-priority enabled pending source to the core, then holds that source as in-service until software writes a completion. Software reaches it as a slave on the peripheral bus.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of request lines; legal range 1..8.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `irq_i` in NUM_SRC: raw peripheral interrupt requests; rising-edge sensitive.
- `we_i` in 1: bus write strobe.
- `addr_i` in 32: bus address; only bits [3:2] are decoded.
- `data_i` in 32: bus write data.
- `data_o` out 32: bus read data, combinational from `addr_i`.
- `int_ack_i` in 1: one-cycle pulse taken from the core's interrupt-entry assert (`int_assert_o` on mtvec entry).
- `int_flag_o` out 8: one-hot flag of the requesting source (bit = id), zero-extended; 8'h00 = `INT_NONE`.
- `int_id_o` out 3: id of the source currently requested or in service.
- `busy_o` out 1: high while a source is in service.

## Operation
Register map (word offsets):
- 0x0 ENABLE: rw, bits [NUM_SRC-1:0], reset 0.
- 0x4 PENDING: read returns pending bits; writing 1 to a bit clears it.
- 0x8 CLAIM: read returns {busy, 28'b0, id}; a write completes service when `data_i[2:0]` equals the in-service id, and is ignored otherwise.
- 0xC STATE: read returns the one-hot state in [2:0].
- Unused read bits return 0.

Edge capture:
- A per-line previous-value register records each input.
- `pending[n]` is set on a 0->1 transition of `irq_i[n]`, whether or not ENABLE[n] is set.
- If a set and a W1C clear land in the same cycle, the set wins.

Selection:
- `cand = pending & ENABLE`.
- The lowest-index set bit wins.

State machine (one-hot), three states:
- S_IDLE:
  - If `cand != 0`, latch the winning id, clear its pending bit, and go to S_REQ.
- S_REQ:
  - `int_flag_o = 1 << id`.
  - `int_ack_i` = 1 -> go to S_SERVE.
  - If ENABLE[id] is cleared before the ack, return to S_IDLE, re-set `pending[id]`, and drop the flag.
- S_SERVE:
  - `int_flag_o` = 0 and `busy_o` = 1.
  - A valid CLAIM write -> go to S_IDLE.
  - A new edge on the in-service line sets its pending bit again; it is re-requested only after completion.

Rules:
- `int_ack_i` outside S_REQ is ignored; this covers acks caused by mret or by sync traps.
- Interrupts do not nest: only one source is in service at a time.

## Timing
Reset values:
- `int_flag_o` = 0, `int_id_o` = 0, `busy_o` = 0.
- ENABLE = 0, PENDING = 0.
- Edge registers = 0 (with synchronizers compiled in, both sync stages = 0).
- State = S_IDLE.

Latencies:
- Edge to pending: bit visible 1 cycle after the clock edge that first samples `irq_i` high (no sync).
- Pending to flag: S_IDLE -> S_REQ takes 1 cycle; `int_flag_o` is registered and valid in the cycle after the transition.
- Ack to drop: `int_flag_o` goes low on the clock edge that samples `int_ack_i` = 1.
- Completion: the next candidate can be requested 1 cycle after the CLAIM write edge; the earliest new `int_flag_o` is 2 cycles after that write.

Other timing rules:
- Bus writes take effect on the clock edge where `we_i` = 1.
- `rst` asserted mid-service returns everything to reset values immediately (asynchronously).

## Configuration
- `INT_CTRL_SYNC_EN` defined: each `irq_i` line passes through a 2-flop synchronizer before edge detection. This adds 2 cycles of edge-to-pending latency, so the pending bit is visible 3 cycles after the first sampling edge.
- `INT_CTRL_SYNC_EN` undefined: `irq_i` feeds edge detection directly. Inputs must be synchronous to `clk`.

## Test plan
- Reset check: hold `rst`=0, then release -> all outputs 0, reads of 0x0/0x4/0x8 = 0, and `int_flag_o` stays 0 with `irq_i` toggling while ENABLE=0; PENDING still records the edges.
- Single source: ENABLE=0x04, pulse `irq_i[2]` -> `int_flag_o`=8'h04 and `int_id_o`=2; `int_ack_i` pulse -> flag 0 and `busy_o`=1; CLAIM read = 0x80000002; write 2 to 0x8 -> `busy_o`=0.
- Priority: ENABLE=0xFF, rising edges on lines 5 and 1 in the same cycle -> line 1 is served first; after completion, `int_flag_o`=8'h20.
- Wrong completion: while serving id 3, write 4 to 0x8 -> `busy_o` stays 1; writing 3 then releases it.
- Enable withdrawn: in S_REQ with id 0, write ENABLE=0 -> `int_flag_o`=0, state S_IDLE, PENDING bit 0 = 1; re-enabling re-requests id 0.
- Collision and reset: W1C of bit 6 in the same cycle as a rising edge on `irq_i[6]` -> PENDING[6]=1. Assert `rst` while in S_SERVE -> outputs 0 immediately. Repeat with and without `INT_CTRL_SYNC_EN`, checking edge-to-pending latency of 1 vs 3 cycles.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt source controller.
// Latches rising edges on up to 8 request lines as pending bits and masks them
// with a software enable register. The highest-priority candidate, which is the
// lowest index, is presented to the core as a one-hot flag. The source is then
// held in service until software writes a matching CLAIM completion.
// Optional build macro: INT_CTRL_SYNC_EN adds a 2-flop synchronizer per request line.
module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    input  logic               int_ack_i,
    output logic [7:0]         int_flag_o,
    output logic [2:0]         int_id_o,
    output logic               busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_REQ   = 3'b010,
        S_SERVE = 3'b100
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] w_irq;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_pend_next;
    logic [2:0]         r_id;
    logic [2:0]         w_id_next;
    logic [2:0]         w_win;
    logic [7:0]         r_flag;
    logic [7:0]         w_enable8;
    logic [7:0]         w_id_onehot8;
    logic [7:0]         w_win_onehot8;
    logic               w_en_wr;
    logic               w_pend_wr;
    logic               w_claim_ok;
    logic               w_unused;

    // Only addr_i[3:2] is decoded; the remaining bus bits are intentionally ignored.
    assign w_unused = ^{addr_i[31:4], addr_i[1:0], data_i};

    assign w_en_wr    = we_i && (addr_i[3:2] == 2'd0);
    assign w_pend_wr  = we_i && (addr_i[3:2] == 2'd1);
    assign w_claim_ok = we_i && (addr_i[3:2] == 2'd2) && (r_state == S_SERVE)
                        && (data_i[2:0] == r_id);

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    // Two-stage synchronizer for asynchronous request lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end
    assign w_irq = r_sync2;
`else
    assign w_irq = irq_i;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_edge
            // Remember each line's previous value so that only 0->1 transitions register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_irq_prev[gi] <= 1'b0;
                else      r_irq_prev[gi] <= w_irq[gi];
            end
            assign w_edge[gi] = w_irq[gi] & ~r_irq_prev[gi];
        end
    endgenerate

    assign w_cand        = r_pending & r_enable;
    assign w_enable8     = 8'(r_enable);
    assign w_id_onehot8  = 8'b1 << r_id;
    assign w_win_onehot8 = 8'b1 << w_win;

    // Priority encoder: the lowest-index candidate wins.
    always_comb begin
        w_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win = 3'(i);
        end
    end

    // Next state, latched id and pending update. Edge sets are applied last so that they win over clears.
    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        w_pend_next  = r_pending;
        if (w_pend_wr) w_pend_next = w_pend_next & ~data_i[NUM_SRC-1:0];
        case (r_state)
            S_IDLE: begin
                if (w_cand != '0) begin
                    w_state_next = S_REQ;
                    w_id_next    = w_win;
                    w_pend_next  = w_pend_next & ~w_win_onehot8[NUM_SRC-1:0];
                end
            end
            S_REQ: begin
                if (int_ack_i) begin
                    w_state_next = S_SERVE;
                end else if (!w_enable8[r_id]) begin
                    // Enable withdrawn before the ack: hand the request back to pending.
                    w_state_next = S_IDLE;
                    w_pend_next  = w_pend_next | w_id_onehot8[NUM_SRC-1:0];
                end
            end
            S_SERVE: begin
                if (w_claim_ok) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_pend_next = w_pend_next | w_edge;
    end

    // State, id, pending, enable and registered flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_flag    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_id      <= w_id_next;
            r_pending <= w_pend_next;
            if (w_en_wr) r_enable <= data_i[NUM_SRC-1:0];
            r_flag    <= (w_state_next == S_REQ) ? (8'b1 << w_id_next) : 8'h00;
        end
    end

    // Combinational bus read mux.
    always_comb begin
        data_o = '0;
        case (addr_i[3:2])
            2'd0: data_o = 32'(r_enable);
            2'd1: data_o = 32'(r_pending);
            2'd2: data_o = {(r_state == S_SERVE), 28'b0, r_id};
            2'd3: data_o = {29'b0, r_state};
            default: data_o = '0;
        endcase
    end

    assign int_flag_o = r_flag;
    assign int_id_o   = r_id;
    assign busy_o     = (r_state == S_SERVE);

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl. Stimulus pushes expectations into
// queues. A monitor process pops and compares them at the falling clock edge.
// Each new flag request is matched against a separate queue of expected {id, flag} values.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_ack_i;
    logic [7:0]  int_flag_o;
    logic [2:0]  int_id_o;
    logic        busy_o;

`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int K_RD   = 0;
    localparam int K_FLAG = 1;
    localparam int K_ID   = 2;
    localparam int K_BUSY = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        q_chk[$];
    logic [10:0] q_ev[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_SRC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_i      (irq_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .int_ack_i  (int_ack_i),
        .int_flag_o (int_flag_o),
        .int_id_o   (int_id_o),
        .busy_o     (busy_o)
    );

    // Monitor: drain point checks and match every new flag request.
    initial begin
        chk_t        c;
        logic [31:0] act;
        logic [10:0] ev_exp;
        logic [7:0]  prev_flag;
        prev_flag = 8'h00;
        forever begin
            @(negedge clk);
            while (q_chk.size() > 0) begin
                c = q_chk.pop_front();
                case (c.kind)
                    K_RD:    act = data_o;
                    K_FLAG:  act = {24'b0, int_flag_o};
                    K_ID:    act = {29'b0, int_id_o};
                    default: act = {31'b0, busy_o};
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", c.name, act, c.exp);
                end else begin
                    $display("check %s ok value=%h", c.name, act);
                end
            end
            if (rst && int_flag_o != 8'h00 && prev_flag == 8'h00) begin
                checks++;
                if (q_ev.size() == 0) begin
                    errors++;
                    $display("FAIL flag_evt: got id=%0d flag=%h required no request", int_id_o, int_flag_o);
                end else begin
                    ev_exp = q_ev.pop_front();
                    if ({int_id_o, int_flag_o} !== ev_exp) begin
                        errors++;
                        $display("FAIL flag_evt: got id=%0d flag=%h required id=%0d flag=%h",
                                 int_id_o, int_flag_o, ev_exp[10:8], ev_exp[7:0]);
                    end else begin
                        $display("request id=%0d flag=%h ok", int_id_o, int_flag_o);
                    end
                end
            end
            prev_flag = int_flag_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        q_chk.push_back(c);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr_i = a;
        expect_val(K_RD, exp, name);
        sample();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        tick();
        we_i   = 1'b0;
        data_i = '0;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_i = m;
        tick();
        irq_i = 8'h00;
    endtask

    task automatic ack_pulse();
        int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0;
    endtask

    task automatic wait_flag(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (int_flag_o != 8'h00) seen = 1'b1;
        end
        #1;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got flag=%h required a request within 30 cycles", name, int_flag_o);
        end
    endtask

    initial begin
        rst = 1'b0; irq_i = 8'h00; we_i = 1'b0; addr_i = '0; data_i = '0; int_ack_i = 1'b0;

        // Reset state
        repeat (3) tick();
        expect_val(K_FLAG, 32'h0, "rst_flag");
        expect_val(K_ID,   32'h0, "rst_id");
        expect_val(K_BUSY, 32'h0, "rst_busy");
        sample();
        rst = 1'b1;
        tick();
        rd_chk(32'h0, 32'h0, "rst_enable");
        rd_chk(32'h4, 32'h0, "rst_pending");
        rd_chk(32'h8, 32'h0, "rst_claim");
        rd_chk(32'hC, 32'h1, "rst_state_idle");

        // Edges are recorded while everything is masked, but nothing is requested.
        tick();
        pulse_irq(8'h81);
        repeat (LAT + 3) tick();
        expect_val(K_FLAG, 32'h0, "masked_flag");
        rd_chk(32'h4, 32'h81, "masked_pending");
        bus_write(32'h4, 32'hFF);
        rd_chk(32'h4, 32'h0, "w1c_pending");

        // Edge-to-pending latency
        tick();
        irq_i = 8'h10;
        repeat (LAT - 1) tick();
        rd_chk(32'h4, 32'h0, "pend_early");
        tick();
        rd_chk(32'h4, 32'h10, "pend_latency");
        irq_i = 8'h00;
        repeat (4) tick();
        bus_write(32'h4, 32'h10);

        // Single source
        bus_write(32'h0, 32'h04);
        q_ev.push_back({3'd2, 8'h04});
        pulse_irq(8'h04);
        wait_flag("single_wait");
        expect_val(K_ID, 32'h2, "single_id");
        sample();
        ack_pulse();
        expect_val(K_FLAG, 32'h0, "single_ack_flag");
        expect_val(K_BUSY, 32'h1, "single_busy");
        sample();
        rd_chk(32'h8, 32'h80000002, "single_claim_rd");
        rd_chk(32'hC, 32'h4, "single_state_serve");
        bus_write(32'h8, 32'h2);
        expect_val(K_BUSY, 32'h0, "single_done_busy");
        sample();
        rd_chk(32'hC, 32'h1, "single_state_idle");

        // Priority: lines 5 and 1 rise together; line 1 is served first.
        bus_write(32'h0, 32'hFF);
        q_ev.push_back({3'd1, 8'h02});
        q_ev.push_back({3'd5, 8'h20});
        pulse_irq(8'h22);
        wait_flag("prio_wait1");
        expect_val(K_ID, 32'h1, "prio_id1");
        sample();
        rd_chk(32'h4, 32'h20, "prio_pending_left");
        ack_pulse();
        bus_write(32'h8, 32'h1);
        wait_flag("prio_wait5");
        expect_val(K_ID, 32'h5, "prio_id5");
        sample();
        ack_pulse();
        bus_write(32'h8, 32'h5);

        // Wrong completion id is ignored.
        q_ev.push_back({3'd3, 8'h08});
        pulse_irq(8'h08);
        wait_flag("wrong_wait");
        ack_pulse();
        bus_write(32'h8, 32'h4);
        expect_val(K_BUSY, 32'h1, "wrong_still_busy");
        sample();
        bus_write(32'h8, 32'h3);
        expect_val(K_BUSY, 32'h0, "right_released");
        sample();

        // Enable withdrawn while the request is outstanding.
        q_ev.push_back({3'd0, 8'h01});
        pulse_irq(8'h01);
        wait_flag("withdraw_wait");
        bus_write(32'h0, 32'h0);
        tick();
        expect_val(K_FLAG, 32'h0, "withdraw_flag");
        sample();
        rd_chk(32'hC, 32'h1, "withdraw_state");
        rd_chk(32'h4, 32'h1, "withdraw_pending");
        q_ev.push_back({3'd0, 8'h01});
        bus_write(32'h0, 32'h01);
        wait_flag("reenable_wait");
        ack_pulse();
        bus_write(32'h8, 32'h0);

        // Rising edge and W1C in the same cycle: the set wins.
        tick();
        irq_i = 8'h40;
        repeat (LAT - 1) tick();
        bus_write(32'h4, 32'h40);
        rd_chk(32'h4, 32'h40, "collision_pending");
        irq_i = 8'h00;
        repeat (4) tick();
        bus_write(32'h4, 32'h40);
        rd_chk(32'h4, 32'h0, "collision_cleared");

        // Asynchronous reset in the middle of service.
        bus_write(32'h0, 32'h02);
        q_ev.push_back({3'd1, 8'h02});
        pulse_irq(8'h02);
        wait_flag("rstsvc_wait");
        ack_pulse();
        expect_val(K_BUSY, 32'h1, "rstsvc_busy_before");
        sample();
        tick();
        addr_i = 32'h0;
        rst = 1'b0;
        #2;
        expect_val(K_BUSY, 32'h0, "rstsvc_busy");
        expect_val(K_ID,   32'h0, "rstsvc_id");
        expect_val(K_FLAG, 32'h0, "rstsvc_flag");
        expect_val(K_RD,   32'h0, "rstsvc_enable");
        sample();
        rst = 1'b1;
        repeat (3) tick();
        rd_chk(32'hC, 32'h1, "post_rst_state");

        checks++;
        if (q_ev.size() != 0) begin
            errors++;
            $display("FAIL ev_queue_empty: got %0d outstanding required 0", q_ev.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
